// File: rtl/counter_sweep_ctrl_if.sv
// rtl/counter_sweep_ctrl_if.sv - control/observe bundle between sweep sequencer, host and counter
interface counter_sweep_ctrl_if #(
  parameter int WIDTH   = 8,
  parameter int SWEEP_W = 4
);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   lo_lim;
  logic [WIDTH-1:0]   hi_lim;
  logic [SWEEP_W-1:0] n_sweeps;
  logic [WIDTH-1:0]   count_in;
  logic               cnt_clr;
  logic               cnt_enable;
  logic               cnt_direction;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [SWEEP_W-1:0] sweep_cnt;

  modport master (
    output start, abort, lo_lim, hi_lim, n_sweeps, count_in,
    input  cnt_clr, cnt_enable, cnt_direction, busy, done, cfg_err, sweep_cnt
  );

  modport slave (
    input  start, abort, lo_lim, hi_lim, n_sweeps, count_in,
    output cnt_clr, cnt_enable, cnt_direction, busy, done, cfg_err, sweep_cnt
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - ping-pongs an external up/down counter between latched limits
module counter_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int SWEEP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_sweep_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SEEK,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [SWEEP_W-1:0] n_q;
  logic [SWEEP_W-1:0] sweep_q;
  logic [SWEEP_W-1:0] sweep_nxt;
  logic               clr_q;
  logic               dir_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               en_c;

  assign sweep_nxt = sweep_q + 1'b1;

  // Enable is decoded from the live count so the counter stops exactly on a limit.
  always_comb begin
    en_c = 1'b0;
    if (!bus.abort) begin
      case (state)
        S_SEEK:  en_c = (bus.count_in < lo_q);
        S_UP:    en_c = (bus.count_in < hi_q);
        S_DOWN:  en_c = (bus.count_in > lo_q);
        default: en_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      sweep_q <= '0;
      clr_q   <= 1'b0;
      dir_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state != S_IDLE && bus.abort) begin
        state  <= S_IDLE;
        busy_q <= 1'b0;
        dir_q  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              if (bus.lo_lim >= bus.hi_lim || bus.n_sweeps == '0) begin
                err_q <= 1'b1;
              end else begin
                lo_q    <= bus.lo_lim;
                hi_q    <= bus.hi_lim;
                n_q     <= bus.n_sweeps;
                sweep_q <= '0;
                clr_q   <= 1'b1;
                busy_q  <= 1'b1;
                dir_q   <= 1'b1;
                state   <= S_CLEAR;
              end
            end
          end
          S_CLEAR: state <= S_SEEK;
          S_SEEK: begin
            if (bus.count_in >= lo_q) state <= S_UP;
          end
          S_UP: begin
            if (bus.count_in >= hi_q) begin
              state <= S_DOWN;
              dir_q <= 1'b0;
            end
          end
          S_DOWN: begin
            if (bus.count_in <= lo_q) begin
              sweep_q <= sweep_nxt;
              dir_q   <= 1'b1;
              if (sweep_nxt == n_q) begin
                state  <= S_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                state <= S_UP;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.cnt_enable    = en_c;
  assign bus.cnt_clr       = clr_q;
  assign bus.cnt_direction = dir_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.cfg_err       = err_q;
  assign bus.sweep_cnt     = sweep_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb/tb_counter_sweep_ctrl.sv - table and scoreboard bench for counter_sweep_ctrl with a counter model
module tb_counter_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  counter_sweep_ctrl_if #(.WIDTH(8), .SWEEP_W(4)) bus ();

  counter_sweep_ctrl #(.WIDTH(8), .SWEEP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Plant: the 8-bit up/down counter, deliberately untouched by rst.
  logic [7:0] cnt = 8'd0;
  always @(posedge clk) begin
    if (bus.cnt_clr)         cnt <= 8'd0;
    else if (bus.cnt_enable) cnt <= bus.cnt_direction ? cnt + 8'd1 : cnt - 8'd1;
  end
  assign bus.count_in = cnt;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] n;
    bit         is_err;
    int         lat;
    int         sweep;
    int         max;
  } vec_t;

  typedef struct {
    bit is_err;
    int lat;
    int sweep;
    int max;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   n_err = 0;
  int   n_checks = 0;
  int   prev_sweep = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " cnt_clr"},       bus.cnt_clr, 0);
    check({tag, " cnt_enable"},    bus.cnt_enable, 0);
    check({tag, " cnt_direction"}, bus.cnt_direction, 1);
    check({tag, " busy"},          bus.busy, 0);
    check({tag, " done"},          bus.done, 0);
    check({tag, " cfg_err"},       bus.cfg_err, 0);
    check({tag, " sweep_cnt"},     bus.sweep_cnt, 0);
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.is_err = v.is_err;
    e.lat    = v.lat;
    e.sweep  = v.is_err ? prev_sweep : v.sweep;
    e.max    = v.max;
    if (!v.is_err) prev_sweep = v.sweep;
    sb.push_back(e);
  endtask

  task automatic drive_start(input logic [7:0] lo, input logic [7:0] hi, input logic [3:0] n);
    @(negedge clk);
    bus.lo_lim   = lo;
    bus.hi_lim   = hi;
    bus.n_sweeps = n;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Called on the first falling edge after the start-sampling edge (cycle 0).
  task automatic wait_result(input string name, input int lo, input int hi, input int poke);
    int   cyc = 0;
    int   mx = 0;
    int   viol = 0;
    bit   clr_seen = 0;
    bit   busy_seen = 0;
    bit   got = 0;
    exp_t e;
    while (!got && cyc < 2000) begin
      if (cyc == poke) begin
        bus.start  = 1'b1;
        bus.hi_lim = 8'd9;
        #1;
      end else if (cyc == poke + 1) begin
        bus.start = 1'b0;
      end
      if (bus.busy && int'(bus.count_in) > mx) mx = int'(bus.count_in);
      if (bus.cnt_enable && bus.cnt_direction && int'(bus.count_in) >= hi) viol++;
      if (bus.cnt_enable && !bus.cnt_direction && int'(bus.count_in) <= lo) viol++;
      clr_seen  = clr_seen | bus.cnt_clr;
      busy_seen = busy_seen | bus.busy;
      if (bus.done || bus.cfg_err) begin
        got = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0;
    if (sb.size() == 0) begin
      check({name, " scoreboard empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({name, " result seen before timeout"}, got, 1);
    if (!got) return;
    check({name, " cfg_err"}, bus.cfg_err, e.is_err);
    check({name, " done"}, bus.done, !e.is_err);
    check({name, " latency"}, cyc, e.lat);
    check({name, " sweep_cnt"}, bus.sweep_cnt, e.sweep);
    check({name, " enable at limit"}, viol, 0);
    if (e.is_err) begin
      check({name, " busy never set"}, busy_seen, 0);
      check({name, " cnt_clr never set"}, clr_seen, 0);
    end else begin
      check({name, " max count"}, mx, e.max);
    end
    @(negedge clk);
    check({name, " pulse width"}, bus.done | bus.cfg_err, 0);
  endtask

  initial begin
    vec_t v;
    int   k;
    vecs[0] = '{lo: 2, hi: 5,  n: 1, is_err: 0, lat: 12, sweep: 1, max: 5};
    vecs[1] = '{lo: 0, hi: 3,  n: 3, is_err: 0, lat: 26, sweep: 3, max: 3};
    vecs[2] = '{lo: 7, hi: 7,  n: 1, is_err: 1, lat: 0,  sweep: 0, max: 0};
    vecs[3] = '{lo: 3, hi: 6,  n: 0, is_err: 1, lat: 0,  sweep: 0, max: 0};
    vecs[4] = '{lo: 1, hi: 2,  n: 2, is_err: 0, lat: 11, sweep: 2, max: 2};
    vecs[5] = '{lo: 9, hi: 4,  n: 2, is_err: 1, lat: 0,  sweep: 0, max: 0};
    vecs[6] = '{lo: 0, hi: 1,  n: 1, is_err: 0, lat: 6,  sweep: 1, max: 1};
    vecs[7] = '{lo: 4, hi: 10, n: 2, is_err: 0, lat: 34, sweep: 2, max: 10};

    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.lo_lim   = 8'd0;
    bus.hi_lim   = 8'd0;
    bus.n_sweeps = 4'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i]);
      drive_start(vecs[i].lo, vecs[i].hi, vecs[i].n);
      wait_result($sformatf("vec%0d", i), int'(vecs[i].lo), int'(vecs[i].hi), -10);
    end

    // Second start and a raised hi_lim mid-run must not disturb the latched run.
    v = '{lo: 2, hi: 5, n: 1, is_err: 0, lat: 12, sweep: 1, max: 5};
    push_exp(v);
    drive_start(v.lo, v.hi, v.n);
    wait_result("midrun", 2, 5, 5);

    // Abort in UP at count 50.
    drive_start(8'd1, 8'd200, 4'd2);
    k = 0;
    while (!(bus.busy && bus.cnt_direction && bus.count_in == 8'd50) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("abort reached 50", k < 500, 1);
    bus.abort = 1'b1;
    #1;
    check("abort enable same cycle", bus.cnt_enable, 0);
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort busy", bus.busy, 0);
    k = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) k++;
    end
    check("abort no done", k, 0);
    check("abort count frozen", bus.count_in, 50);
    check("abort sweep_cnt holds", bus.sweep_cnt, 0);

    // Abort together with start in IDLE: start is ignored.
    @(negedge clk);
    bus.lo_lim = 8'd2; bus.hi_lim = 8'd5; bus.n_sweeps = 4'd1;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("idle abort busy", bus.busy, 0);
    check("idle abort cnt_clr", bus.cnt_clr, 0);

    // Asynchronous reset mid-DOWN, then a clean rerun.
    v = '{lo: 2, hi: 5, n: 1, is_err: 0, lat: 12, sweep: 1, max: 5};
    drive_start(v.lo, v.hi, v.n);
    k = 0;
    while (!(bus.busy && !bus.cnt_direction) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reached DOWN", k < 100, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals("midrun reset");
    @(negedge clk);
    rst = 1'b1;
    prev_sweep = 0;
    push_exp(v);
    drive_start(v.lo, v.hi, v.n);
    wait_result("after reset", 2, 5, -10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
